// File: rtl/top_lvl_systolic_pkg.sv
// top_lvl_systolic_pkg: shared array dimensions and phase encoding.
// Rev 1.0
`default_nettype none

package top_lvl_systolic_pkg;
  localparam int N        = 4;
  localparam int NUM_BITS = 8;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } phase_t;
endpackage

`default_nettype wire

// File: rtl/top_lvl_systolic_pe.sv
// top_lvl_systolic_pe: one weight-stationary cell (weight, activation, accumulator, MAC).
// Rev 1.0
`default_nettype none

module top_lvl_systolic_pe
  import top_lvl_systolic_pkg::*;
#(
  parameter int NUM_BITS = top_lvl_systolic_pkg::NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  phase_t              phase,
  input  logic                clear,
  input  logic [NUM_BITS-1:0] w_in,
  input  logic [NUM_BITS-1:0] a_in,
  output logic [NUM_BITS-1:0] w_out,
  output logic [NUM_BITS-1:0] a_out,
  output logic [NUM_BITS-1:0] acc
);

  logic [NUM_BITS-1:0] w;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] prod;

  // Product truncates to the data width; the sum wraps.
  assign prod = a * w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w   <= '0;
      a   <= '0;
      acc <= '0;
    end else if (phase == LOAD) begin
      w <= w_in;
      a <= '0;
      if (clear) acc <= '0;
    end else begin
      a   <= a_in;
      acc <= acc + prod;
    end
  end

  assign w_out = w;
  assign a_out = a;

endmodule

`default_nettype wire

// File: rtl/top_lvl_systolic.sv
// top_lvl_systolic: N x N weight-stationary systolic array with LOAD/COMPUTE phase controller.
// Rev 1.0
`default_nettype none

module top_lvl_systolic
  import top_lvl_systolic_pkg::*;
#(
  parameter int N        = top_lvl_systolic_pkg::N,
  parameter int NUM_BITS = top_lvl_systolic_pkg::NUM_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0][NUM_BITS-1:0]           north_i,
  input  logic [N-1:0][NUM_BITS-1:0]           west_i,
  output logic [N-1:0][N-1:0][NUM_BITS-1:0]    C_o
);

  localparam int             CNT_W        = $clog2(3 * N);
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(3 * N - 2);

  phase_t             phase;
  phase_t             phase_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               clear;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= LOAD;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt + 1'b1;
    clear     = (phase == LOAD) && (cnt == '0);
    case (phase)
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          phase_nxt = COMPUTE;
          cnt_nxt   = '0;
        end
      end
      COMPUTE: begin
        if (cnt == COMPUTE_LAST) begin
          phase_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        phase_nxt = LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Weights flow south, activations flow east; the far edges fall off the array.
  logic [N:0][N-1:0][NUM_BITS-1:0] w_bus;
  logic [N-1:0][N:0][NUM_BITS-1:0] a_bus;
  logic                            unused_w_edge;

  assign w_bus[0]      = north_i;
  assign unused_w_edge = ^w_bus[N];

  for (genvar i = 0; i < N; i++) begin : g_row
    logic unused_a_edge;
    assign a_bus[i][0]   = west_i[i];
    assign unused_a_edge = ^a_bus[i][N];

    for (genvar j = 0; j < N; j++) begin : g_col
      top_lvl_systolic_pe #(
        .NUM_BITS (NUM_BITS)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .clear (clear),
        .w_in  (w_bus[i][j]),
        .a_in  (a_bus[i][j]),
        .w_out (w_bus[i+1][j]),
        .a_out (a_bus[i][j+1]),
        .acc   (C_o[i][j])
      );
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_top_lvl_systolic.sv
// tb_top_lvl_systolic: table-driven and randomized checks of the systolic array.
// Rev 1.0
`default_nettype none

module tb_top_lvl_systolic;
  import top_lvl_systolic_pkg::*;

  localparam int TC = 3 * N - 1;

  typedef logic [N-1:0][NUM_BITS-1:0]        row_t;
  typedef logic [N-1:0][N-1:0][NUM_BITS-1:0] mat_t;
  typedef logic [TC-1:0][N-1:0][NUM_BITS-1:0] west_t;

  typedef struct {
    string name;
    mat_t  north;   // [load cycle][column]
    west_t west;    // [compute cycle][row]
    mat_t  expect_c;
  } vec_t;

  logic clk;
  logic rst;
  row_t north_i;
  row_t west_i;
  mat_t C_o;

  int vectors;
  int miscompares;

  top_lvl_systolic #(
    .N        (N),
    .NUM_BITS (NUM_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .north_i (north_i),
    .west_i  (west_i),
    .C_o     (C_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < N; j++) r[j] = NUM_BITS'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input mat_t act, input mat_t exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: C_o=%h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: weight of row r is what column j saw in LOAD cycle N-1-r; an
  // activation injected at compute cycle t reaches column j in time only if
  // t+j+1 is still a COMPUTE cycle index.
  function automatic mat_t model(input mat_t nm, input west_t wm);
    mat_t                c;
    logic [NUM_BITS-1:0] w;
    logic [NUM_BITS-1:0] p;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w = nm[N-1-i][j];
        for (int t = 0; t < TC; t++)
          if (t + j + 1 <= TC - 1) begin
            p       = wm[t][i] * w;
            c[i][j] = c[i][j] + p;
          end
      end
    return c;
  endfunction

  task automatic run_txn(input vec_t v);
    for (int k = 0; k < N; k++) begin
      north_i = v.north[k];
      west_i  = rand_row();
      step;
      if (k == 0) check({v.name, "_clear"}, C_o, '0);
    end
    for (int t = 0; t < TC; t++) begin
      north_i = rand_row();
      west_i  = v.west[t];
      step;
    end
    check(v.name, C_o, v.expect_c);
  endtask

  vec_t vecs[$];
  vec_t v;
  vec_t ident;
  mat_t exp_m;
  row_t ones;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int j = 0; j < N; j++) ones[j] = NUM_BITS'(1);

    v.name = "identity"; v.north = '0; v.west = '0; v.expect_c = '0;
    for (int k = 0; k < N; k++) v.north[k][N-1-k] = NUM_BITS'(1);
    for (int i = 0; i < N; i++) begin
      v.west[2*i][i]  = NUM_BITS'(1);
      v.expect_c[i][i] = NUM_BITS'(1);
    end
    vecs.push_back(v);
    ident = v;

    v.name = "all_ones"; v.west = '0;
    for (int k = 0; k < N; k++) v.north[k] = ones;
    for (int i = 0; i < N; i++) begin
      for (int t = i; t < i + 4; t++) v.west[t][i] = NUM_BITS'(1);
      for (int j = 0; j < N; j++) v.expect_c[i][j] = NUM_BITS'(4);
    end
    vecs.push_back(v);

    v.name = "wrap"; v.north = '1; v.west = '0; v.expect_c = '0;
    for (int t = 0; t < 3; t++) v.west[t][0] = '1;
    for (int j = 0; j < N; j++) v.expect_c[0][j] = NUM_BITS'(3);
    vecs.push_back(v);

    v.name = "late_drop"; v.west = '0; v.expect_c = '0;
    for (int k = 0; k < N; k++) v.north[k] = ones;
    v.west[TC-3] = ones;
    for (int i = 0; i < N; i++) begin
      v.expect_c[i][0] = NUM_BITS'(1);
      v.expect_c[i][1] = NUM_BITS'(1);
    end
    vecs.push_back(v);

    for (int n = 0; n < 20; n++) begin
      v.name = $sformatf("rand%0d", n);
      for (int k = 0; k < N; k++) v.north[k] = rand_row();
      for (int t = 0; t < TC; t++) begin
        v.west[t] = rand_row();
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 2) == 0) v.west[t][i] = '0;
      end
      v.expect_c = model(v.north, v.west);
      vecs.push_back(v);
    end

    rst = 1'b0; north_i = '0; west_i = '0;
    repeat (3) step;
    rst = 1'b1;
    check("reset_state", C_o, '0);

    foreach (vecs[n]) run_txn(vecs[n]);

    // Abort mid-COMPUTE: weights all 1, five cycles of activation 1.
    for (int k = 0; k < N; k++) begin
      north_i = ones;
      west_i  = rand_row();
      step;
    end
    for (int t = 0; t < 5; t++) begin
      north_i = rand_row();
      west_i  = ones;
      step;
    end
    exp_m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_m[i][j] = (j < 4) ? NUM_BITS'(4 - j) : '0;
    check("mid_compute", C_o, exp_m);
    rst = 1'b0;
    step;
    check("reset_abort", C_o, '0);
    rst = 1'b1;
    ident.name = "identity_after_reset";
    run_txn(ident);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
